nearest_upsample: RTL and testbench
===================================

// Module: nearest_upsample
// PURPOSE
//  Streaming nearest-neighbour upsampler; the inverse of max_pool on the feature_if stream.
//  - Accepts an IMAGE_HEIGHT x IMAGE_WIDTH raster-order frame on features_in.
//  - Emits an (IMAGE_HEIGHT*ROW_STRIDE) x (IMAGE_WIDTH*COL_STRIDE) raster-order frame on features_out.
//  - Each input pixel is replicated into a ROW_STRIDE x COL_STRIDE block.
//  - Used as a decoder/unpool stage and as a frame generator for max_pool round-trip checks.
// PARAMETERS
//  IMAGE_HEIGHT  6  input rows per frame (>=1)
//  IMAGE_WIDTH   6  input columns per frame (>=1)
//  ROW_STRIDE    2  vertical replication factor (>=1)
//  COL_STRIDE    2  horizontal replication factor (>=1)
//  OUT_HEIGHT    IMAGE_HEIGHT*ROW_STRIDE, derived (localparam)
//  OUT_WIDTH     IMAGE_WIDTH*COL_STRIDE, derived (localparam)
// PORTS
//  clock         input   1          single clock, rising edge
//  reset_n       input   1          asynchronous active-low reset
//  features_in   feature_if  -      input stream: valid, ready (driven here), features[]
//  features_out  feature_if  -      output stream: valid (driven here), ready, features[]
// BEHAVIOUR
//  - Reset: features_out.valid=0, features_out.features='0, features_in.ready=0.
//    State=FIRST; all counters 0; line buffer contents don't-care.
//  - Handshakes: transfer occurs when valid&&ready at a rising clock edge.
//    features_out.features must hold stable while valid&&!ready.
//  - All lanes of features[] are replicated together; feature_type width is unchanged (no arithmetic).
//  - Counters:
//    rep_cnt 0..COL_STRIDE-1 (copy within block), col_cnt 0..IMAGE_WIDTH-1,
//    pass_cnt 0..ROW_STRIDE-1 (output row within block), row_cnt 0..IMAGE_HEIGHT-1.
//  - FIRST (pass_cnt==0):
//    - features_in.ready = !out_valid || (features_out.ready && rep_cnt==COL_STRIDE-1).
//    - An accepted pixel is registered to the output and written to line buffer[col_cnt].
//    - It is then emitted COL_STRIDE times.
//  - REPEAT (pass_cnt>0): features_in.ready=0.
//    - Reads line buffer[col_cnt] and emits each entry COL_STRIDE times.
//    - Occurs for passes 1..ROW_STRIDE-1.
//  - Transitions:
//    - End of row pass (last rep of col IMAGE_WIDTH-1 accepted): pass_cnt++ and go to REPEAT,
//      or, if pass_cnt==ROW_STRIDE-1, set pass_cnt=0, row_cnt++ and go to FIRST.
//    - At row_cnt==IMAGE_HEIGHT-1, row_cnt wraps to 0.
//    - The next frame follows with no idle cycle.
//  - Latency: first output valid 1 cycle after input acceptance.
//  - Throughput: 1 output/cycle with features_out.ready held high; input accepted 1 per COL_STRIDE cycles.
//  - Backpressure: !features_out.ready freezes all counters; no output is dropped or duplicated.
//  - ROW_STRIDE==1: REPEAT is never entered.
//  - ROW_STRIDE==COL_STRIDE==1: behaves as a 1-deep registered pipe.
//  - Reset mid-frame: partial frame discarded, outputs return to reset values.
//    The next accepted pixel is frame pixel (0,0).
//  - features_in.valid low: output valid drops after the last copy is consumed (in FIRST only).
// STRUCTURE
//  - mnist_pkg provides feature_type.
//  - Add to mnist_pkg: typedef enum logic {UPS_FIRST, UPS_REPEAT} ups_state_t.
//  - Sub-module feature_line_buffer: IMAGE_WIDTH-deep array of feature_type, 1 write port + 1 read port.
//    Registered read, addressed by col_cnt; read issued one cycle ahead for REPEAT.
//  - Counters, FSM and output register live in nearest_upsample.
// TESTING
//  1. Defaults; 3x3 frame {8,5,9/9,8,7/7,8,9}; out ready=1.
//     -> 6x6 output, row0 = 8 8 5 5 9 9 and row1 equal to row0.
//     -> 36 transfers; input ready low during each REPEAT pass.
//  2. Same frame with features_out.ready toggling 1-0-0-1.
//     -> identical 36-value sequence; data stable during every stall.
//  3. ROW_STRIDE=3, COL_STRIDE=1, 2x2 frame {1,2/3,4}.
//     -> rows 12,12,12,34,34,34 (6x2 output).
//  4. Both strides 1, 2x2 frame {4,3/2,1}.
//     -> output equals input, 1-cycle latency, ready high every cycle.
//  5. Assert reset_n low after output 10 of test 1, then resend the frame.
//     -> valid=0 during reset; full correct 36-value frame afterwards.
//  6. Two back-to-back frames (test 1 frame, then all 7s).
//     -> 72 outputs, no gap cycle, second frame all 7.
//     -> max_pool fed with this output reproduces the input frame.

Source files
------------

// File: rtl/mnist_pkg.sv
// mnist_pkg: shared feature types, upsampler state encoding and counter sizing helper.
// Rev 1.0
`default_nettype none

package mnist_pkg;

  localparam int FEATURE_WIDTH = 8;
  localparam int FEATURE_LANES = 2;

  typedef logic [FEATURE_WIDTH-1:0] feature_type;
  typedef feature_type [FEATURE_LANES-1:0] feature_vec_t;

  typedef enum logic {UPS_FIRST, UPS_REPEAT} ups_state_t;

  // Counters over a range of one still need a 1-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/feature_if.sv
// feature_if: valid/ready stream carrying all feature lanes of one pixel per beat.
// Rev 1.0
`default_nettype none

interface feature_if;
  import mnist_pkg::*;

  logic         valid;
  logic         ready;
  feature_vec_t features;

  modport master (output valid, output features, input ready);
  modport slave  (input valid, input features, output ready);

endinterface

`default_nettype wire

// File: rtl/feature_line_buffer.sv
// feature_line_buffer: one input row of pixels, one write port and one registered read port.
// Rev 1.0
`default_nettype none

module feature_line_buffer
  import mnist_pkg::*;
#(
  parameter int DEPTH  = 6,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  feature_vec_t      wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output feature_vec_t      rd_data_o
);

  feature_vec_t mem_q [DEPTH];
  feature_vec_t rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Write-first: a one-column row reads back the pixel written on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_q <= wr_data_i;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/nearest_upsample.sv
// nearest_upsample: streaming nearest-neighbour upsampler, each pixel replicated into a
// ROW_STRIDE x COL_STRIDE block. Rev 1.0
`default_nettype none

module nearest_upsample
  import mnist_pkg::*;
#(
  parameter int IMAGE_HEIGHT = 6,
  parameter int IMAGE_WIDTH  = 6,
  parameter int ROW_STRIDE   = 2,
  parameter int COL_STRIDE   = 2
) (
  input  logic      clock,
  input  logic      reset_n,
  feature_if.slave  features_in,
  feature_if.master features_out
);

  localparam int OUT_HEIGHT = IMAGE_HEIGHT * ROW_STRIDE;
  localparam int OUT_WIDTH  = IMAGE_WIDTH * COL_STRIDE;

  localparam int REP_W  = cnt_width(COL_STRIDE);
  localparam int COL_W  = cnt_width(IMAGE_WIDTH);
  localparam int PASS_W = cnt_width(ROW_STRIDE);
  localparam int ROW_W  = cnt_width(IMAGE_HEIGHT);

  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(COL_STRIDE - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(ROW_STRIDE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMAGE_HEIGHT - 1);

  if (IMAGE_HEIGHT < 1 || IMAGE_WIDTH < 1 || ROW_STRIDE < 1 || COL_STRIDE < 1 ||
      OUT_HEIGHT < IMAGE_HEIGHT || OUT_WIDTH < IMAGE_WIDTH) begin : g_bad_params
    $error("nearest_upsample: dimensions and strides must all be >= 1");
  end

  ups_state_t        state_q, state_d;
  logic [REP_W-1:0]  rep_q,   rep_d;
  logic [COL_W-1:0]  col_q,   col_d;
  logic [PASS_W-1:0] pass_q,  pass_d;
  logic [ROW_W-1:0]  row_q,   row_d;
  logic              out_valid_q, out_valid_d;
  feature_vec_t      out_data_q,  out_data_d;

  logic              lb_we;
  logic [COL_W-1:0]  lb_waddr;
  logic [COL_W-1:0]  lb_raddr;
  feature_vec_t      lb_rdata;

  logic rep_last, col_last, pass_last, row_last;
  logic out_fire, in_ready, in_fire;

  function automatic logic [COL_W-1:0] col_succ(input logic [COL_W-1:0] c);
    return (c == COL_LAST) ? '0 : c + 1'b1;
  endfunction

  assign rep_last  = (rep_q == REP_LAST);
  assign col_last  = (col_q == COL_LAST);
  assign pass_last = (pass_q == PASS_LAST);
  assign row_last  = (row_q == ROW_LAST);

  assign out_fire = out_valid_q && features_out.ready;

  // A new pixel may only replace the last copy of the current one, and never at the
  // end of a first pass that is followed by REPEAT passes.
  assign in_ready = reset_n && (state_q == UPS_FIRST) &&
                    (!out_valid_q ||
                     (features_out.ready && rep_last && !(col_last && !pass_last)));
  assign in_fire  = features_in.valid && in_ready;

  always_comb begin
    state_d     = state_q;
    rep_d       = rep_q;
    col_d       = col_q;
    pass_d      = pass_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    lb_we       = 1'b0;

    if (out_fire) begin
      if (!rep_last) begin
        rep_d = rep_q + 1'b1;
      end else begin
        rep_d = '0;
        if (!col_last) begin
          col_d = col_q + 1'b1;
        end else begin
          col_d = '0;
          if (!pass_last) begin
            pass_d  = pass_q + 1'b1;
            state_d = UPS_REPEAT;
          end else begin
            pass_d  = '0;
            state_d = UPS_FIRST;
            row_d   = row_last ? '0 : row_q + 1'b1;
          end
        end
        if (state_d == UPS_REPEAT) begin
          out_data_d = lb_rdata;
        end else begin
          out_valid_d = 1'b0;
        end
      end
    end

    if (in_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = features_in.features;
      lb_we       = 1'b1;
    end

    // Counters describe the pixel held at the output, so the read that follows is
    // always the column after the next position.
    lb_waddr = col_d;
    lb_raddr = col_succ(col_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= UPS_FIRST;
      rep_q       <= '0;
      col_q       <= '0;
      pass_q      <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rep_q       <= rep_d;
      col_q       <= col_d;
      pass_q      <= pass_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  feature_line_buffer #(
    .DEPTH  (IMAGE_WIDTH),
    .ADDR_W (COL_W)
  ) u_line_buffer (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en_i   (lb_we),
    .wr_addr_i (lb_waddr),
    .wr_data_i (features_in.features),
    .rd_addr_i (lb_raddr),
    .rd_data_o (lb_rdata)
  );

  assign features_in.ready     = in_ready;
  assign features_out.valid    = out_valid_q;
  assign features_out.features = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_nearest_upsample.sv
// tb_nearest_upsample: scoreboard bench for three upsampler configurations.
// Rev 1.0
`default_nettype none

module tb_nearest_upsample;
  import mnist_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  feature_if ifa_in(), ifa_out(), ifb_in(), ifb_out(), ifc_in(), ifc_out();

  nearest_upsample #(.IMAGE_HEIGHT(3), .IMAGE_WIDTH(3), .ROW_STRIDE(2), .COL_STRIDE(2))
    dut_a (.clock(clk), .reset_n(rst_n), .features_in(ifa_in), .features_out(ifa_out));
  nearest_upsample #(.IMAGE_HEIGHT(2), .IMAGE_WIDTH(2), .ROW_STRIDE(3), .COL_STRIDE(1))
    dut_b (.clock(clk), .reset_n(rst_n), .features_in(ifb_in), .features_out(ifb_out));
  nearest_upsample #(.IMAGE_HEIGHT(2), .IMAGE_WIDTH(2), .ROW_STRIDE(1), .COL_STRIDE(1))
    dut_c (.clock(clk), .reset_n(rst_n), .features_in(ifc_in), .features_out(ifc_out));

  int           sel = 0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  feature_vec_t in_feat = '0;

  logic         obs_in_ready, obs_out_valid;
  feature_vec_t obs_out_feat;

  always_comb begin
    ifa_in.valid    = in_valid && (sel == 0);
    ifb_in.valid    = in_valid && (sel == 1);
    ifc_in.valid    = in_valid && (sel == 2);
    ifa_in.features = in_feat;
    ifb_in.features = in_feat;
    ifc_in.features = in_feat;
    ifa_out.ready   = (sel == 0) ? out_ready : 1'b1;
    ifb_out.ready   = (sel == 1) ? out_ready : 1'b1;
    ifc_out.ready   = (sel == 2) ? out_ready : 1'b1;
    case (sel)
      1:       begin obs_in_ready = ifb_in.ready; obs_out_valid = ifb_out.valid; obs_out_feat = ifb_out.features; end
      2:       begin obs_in_ready = ifc_in.ready; obs_out_valid = ifc_out.valid; obs_out_feat = ifc_out.features; end
      default: begin obs_in_ready = ifa_in.ready; obs_out_valid = ifa_out.valid; obs_out_feat = ifa_out.features; end
    endcase
  end

  int checks = 0;
  int failures = 0;

  logic [7:0]   frame_buf [$];
  feature_vec_t stim_q [$];
  feature_vec_t exp_q [$];

  function automatic feature_vec_t lanes(input logic [7:0] v);
    return {v ^ 8'hA5, v};
  endfunction

  // Reference model: output pixel (r,c) is input pixel (r/rs, c/cs).
  task automatic load_frame(input int h, input int w, input int rs, input int cs);
    for (int i = 0; i < h * w; i++) stim_q.push_back(lanes(frame_buf[i]));
    for (int r = 0; r < h * rs; r++)
      for (int c = 0; c < w * cs; c++)
        exp_q.push_back(lanes(frame_buf[(r / rs) * w + c / cs]));
  endtask

  task automatic drive_inputs();
    in_valid = (stim_q.size() > 0);
    in_feat  = in_valid ? stim_q[0] : '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs_out_valid !== 1'b0 || obs_out_feat !== '0 || obs_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got valid=%b feat=%h in_ready=%b exp 0/0/0", obs_out_valid, obs_out_feat, obs_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc = 0, n = 0, viol = 0;
    feature_vec_t exp_v;
    sel = 0; out_ready = 1'b1;
    frame_buf = '{8'd8, 8'd5, 8'd9, 8'd9, 8'd8, 8'd7, 8'd7, 8'd8, 8'd9};
    load_frame(3, 3, 2, 2);
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      drive_inputs();
      #1;
      if (in_valid && obs_in_ready) void'(stim_q.pop_front());
      if (obs_out_valid && ((n / 6) % 2 == 1) && obs_in_ready) viol++;
      if (obs_out_valid && out_ready) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_out_feat !== exp_v) begin
          failures++;
          $display("FAIL basic_out[%0d] got=%h exp=%h", n, obs_out_feat, exp_v);
        end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 36) begin failures++; $display("FAIL basic_count got=%0d exp=36", n); end
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL basic_ready_in_repeat got=%0d exp=0", viol); end
    exp_q.delete(); stim_q.delete();
  endtask

  task automatic test_backpressure();
    int cyc = 0, n = 0;
    logic prev_valid = 1'b0, prev_ready = 1'b1;
    feature_vec_t prev_feat = '0, exp_v;
    sel = 0;
    frame_buf = '{8'd8, 8'd5, 8'd9, 8'd9, 8'd8, 8'd7, 8'd7, 8'd8, 8'd9};
    load_frame(3, 3, 2, 2);
    while (exp_q.size() > 0 && cyc < 800) begin
      @(negedge clk); cyc++;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      drive_inputs();
      #1;
      if (prev_valid && !prev_ready) begin
        checks++;
        if (obs_out_valid !== 1'b1 || obs_out_feat !== prev_feat) begin
          failures++;
          $display("FAIL stall_stable got valid=%b feat=%h exp 1/%h", obs_out_valid, obs_out_feat, prev_feat);
        end
      end
      if (in_valid && obs_in_ready) void'(stim_q.pop_front());
      if (obs_out_valid && out_ready) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_out_feat !== exp_v) begin
          failures++;
          $display("FAIL bp_out[%0d] got=%h exp=%h", n, obs_out_feat, exp_v);
        end
        n++;
      end
      prev_valid = obs_out_valid; prev_ready = out_ready; prev_feat = obs_out_feat;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (n !== 36) begin failures++; $display("FAIL bp_count got=%0d exp=36", n); end
    exp_q.delete(); stim_q.delete();
  endtask

  task automatic test_row_stride3();
    int cyc = 0, n = 0;
    feature_vec_t exp_v;
    sel = 1; out_ready = 1'b1;
    frame_buf = '{8'd1, 8'd2, 8'd3, 8'd4};
    load_frame(2, 2, 3, 1);
    while (exp_q.size() > 0 && cyc < 200) begin
      @(negedge clk); cyc++;
      drive_inputs();
      #1;
      if (in_valid && obs_in_ready) void'(stim_q.pop_front());
      if (obs_out_valid && out_ready) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_out_feat !== exp_v) begin
          failures++;
          $display("FAIL rs3_out[%0d] got=%h exp=%h", n, obs_out_feat, exp_v);
        end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 12) begin failures++; $display("FAIL rs3_count got=%0d exp=12", n); end
    exp_q.delete(); stim_q.delete();
  endtask

  task automatic test_pipe();
    int cyc = 0, n = 0, acc;
    int acc_q [$];
    feature_vec_t exp_v;
    sel = 2; out_ready = 1'b1;
    frame_buf = '{8'd4, 8'd3, 8'd2, 8'd1};
    load_frame(2, 2, 1, 1);
    while (exp_q.size() > 0 && cyc < 100) begin
      @(negedge clk); cyc++;
      drive_inputs();
      #1;
      checks++;
      if (obs_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL pipe_in_ready cycle %0d got=%b exp=1", cyc, obs_in_ready);
      end
      if (obs_out_valid && out_ready) begin
        exp_v = exp_q.pop_front();
        acc = (acc_q.size() > 0) ? acc_q.pop_front() : -10;
        checks++;
        if (obs_out_feat !== exp_v || cyc !== acc + 1) begin
          failures++;
          $display("FAIL pipe_out[%0d] got=%h@%0d exp=%h@%0d", n, obs_out_feat, cyc, exp_v, acc + 1);
        end
        n++;
      end
      if (in_valid && obs_in_ready) begin void'(stim_q.pop_front()); acc_q.push_back(cyc); end
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 4) begin failures++; $display("FAIL pipe_count got=%0d exp=4", n); end
    exp_q.delete(); stim_q.delete();
  endtask

  task automatic test_reset_midframe();
    int cyc = 0, n = 0;
    feature_vec_t exp_v;
    sel = 0; out_ready = 1'b1;
    frame_buf = '{8'd8, 8'd5, 8'd9, 8'd9, 8'd8, 8'd7, 8'd7, 8'd8, 8'd9};
    load_frame(3, 3, 2, 2);
    while (n < 10 && cyc < 200) begin
      @(negedge clk); cyc++;
      drive_inputs();
      #1;
      if (in_valid && obs_in_ready) void'(stim_q.pop_front());
      if (obs_out_valid && out_ready) begin void'(exp_q.pop_front()); n++; end
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    exp_q.delete(); stim_q.delete();
    repeat (2) begin
      #1;
      checks++;
      if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL midreset_state got valid=%b in_ready=%b exp 0/0", obs_out_valid, obs_in_ready);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    load_frame(3, 3, 2, 2);
    cyc = 0; n = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      drive_inputs();
      #1;
      if (in_valid && obs_in_ready) void'(stim_q.pop_front());
      if (obs_out_valid && out_ready) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_out_feat !== exp_v) begin
          failures++;
          $display("FAIL after_reset_out[%0d] got=%h exp=%h", n, obs_out_feat, exp_v);
        end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 36) begin failures++; $display("FAIL after_reset_count got=%0d exp=36", n); end
    exp_q.delete(); stim_q.delete();
  endtask

  task automatic test_back_to_back();
    int cyc = 0, n = 0;
    logic [7:0] cap [$];
    logic [7:0] f1 [$];
    logic [7:0] m, v;
    feature_vec_t exp_v;
    sel = 0; out_ready = 1'b1;
    f1 = '{8'd8, 8'd5, 8'd9, 8'd9, 8'd8, 8'd7, 8'd7, 8'd8, 8'd9};
    frame_buf = f1;
    load_frame(3, 3, 2, 2);
    frame_buf = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
    load_frame(3, 3, 2, 2);
    while (exp_q.size() > 0 && cyc < 800) begin
      @(negedge clk); cyc++;
      drive_inputs();
      #1;
      if (in_valid && obs_in_ready) void'(stim_q.pop_front());
      if (obs_out_valid && out_ready) begin
        exp_v = exp_q.pop_front();
        cap.push_back(obs_out_feat[0]);
        checks++;
        if (obs_out_feat !== exp_v) begin
          failures++;
          $display("FAIL b2b_out[%0d] got=%h exp=%h", n, obs_out_feat, exp_v);
        end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 72) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=72", n);
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          m = 8'd0;
          for (int d = 0; d < 4; d++) begin
            v = cap[(2 * r + d / 2) * 6 + 2 * c + d % 2];
            if (v > m) m = v;
          end
          checks++;
          if (m !== f1[r * 3 + c]) begin
            failures++;
            $display("FAIL maxpool_roundtrip(%0d,%0d) got=%0d exp=%0d", r, c, m, f1[r * 3 + c]);
          end
        end
      end
    end
    exp_q.delete(); stim_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_row_stride3();
    test_pipe();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
